// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
// Shared definitions for the four-digit seven-segment scan controller:
//   scan_state_t : scan FSM states (BLANK = all anodes off, DRIVE = one anode on)
//   SEG_FONT     : 16-entry hex font, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   AN_OFF       : all anodes off
package seg_scan_ctrl_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_FONT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg_scan_ctrl_hex2seg.sv
// hex2seg
// Purely combinational hex-nibble to seven-segment decoder (active-low).
// Ports:
//   nibble : 4-bit hex value
//   seg_n  : 7-bit active-low segment pattern {g,f,e,d,c,b,a}
module hex2seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_FONT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each digit gets BLANK_CYC cycles with every anode off (ghosting guard)
// followed by TICK_DIV cycles with its own anode driven. New data is staged
// in a pending register and promoted to the displayed (active) register only
// at the end of digit 3, so a frame never mixes old and new values.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data_in    : four hex nibbles, nibble i drives digit i (digit 3 = MSD)
//   dp_in      : per-digit decimal point request, active-high
//   load       : capture strobe for data_in / dp_in
//   blank_lz   : leading-zero blanking enable, sampled live
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         : decimal point, active-low, registered
//   an         : digit anodes, active-low, registered
//   frame_done : one-cycle pulse during the frame-boundary cycle
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DRIVE_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t      state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic [15:0] act_data;
  logic [3:0]  act_dp;

  logic        boundary;
  logic        boundary_next;
  logic [3:0]  nib_p0;
  logic        lz_blank_p0;
  logic        shown_p0;
  logic [6:0]  font_p0;

  // Last DRIVE cycle of digit 3: the promotion cycle.
  assign boundary      = (state == DRIVE) && (idx == 2'd3) && (cnt == DRIVE_LAST);
  // One cycle earlier, so the registered frame_done lines up with the boundary.
  assign boundary_next = (state == DRIVE) && (idx == 2'd3) && (cnt == DRIVE_PRE);

  // Staging: pending always holds the most recent load, so copying it at
  // every boundary is correct whether or not a new load arrived this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (boundary) begin
        act_data <= load ? data_in : pend_data;
        act_dp   <= load ? dp_in   : pend_dp;
      end
    end
  end

  // ---- stage p0: digit select, leading-zero test, decode ----
  always_comb begin
    nib_p0 = act_data[3:0];
    case (idx)
      2'd0:    nib_p0 = act_data[3:0];
      2'd1:    nib_p0 = act_data[7:4];
      2'd2:    nib_p0 = act_data[11:8];
      default: nib_p0 = act_data[15:12];
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble are 0.
  always_comb begin
    lz_blank_p0 = 1'b0;
    if (blank_lz) begin
      case (idx)
        2'd3:    lz_blank_p0 = (act_data[15:12] == 4'h0);
        2'd2:    lz_blank_p0 = (act_data[15:8]  == 8'h00);
        2'd1:    lz_blank_p0 = (act_data[15:4]  == 12'h000);
        default: lz_blank_p0 = 1'b0;
      endcase
    end
  end

  assign shown_p0 = (state == DRIVE) && !lz_blank_p0;

  hex2seg u_hex2seg (
    .nibble (nib_p0),
    .seg_n  (font_p0)
  );

  // ---- stage p1: scan FSM and registered display outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_next;
      an         <= (state == DRIVE) ? ~(4'b0001 << idx) : AN_OFF;
      seg        <= shown_p0 ? font_p0 : SEG_OFF;
      dp         <= shown_p0 ? ~act_dp[idx] : 1'b1;

      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + 2'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with TICK_DIV=4, BLANK_CYC=2
// (6 cycles per digit, 24 cycles per frame). cyc counts rising edges since
// the last reset release; outputs are sampled 1 time unit after each edge.
// With this timing, digit i of frame k is visible on edges 3+24k+6i ..
// 6+24k+6i, and frame_done is high after edge 23+24k.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp;
  int n_bad;
  int cyc;

  seg_scan_ctrl #(
    .TICK_DIV  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input int k, input int i, input logic [6:0] es, input logic ed);
    logic [3:0] ea;
    ea = ~(4'b0001 << i);
    wait_cyc(4 + 24 * k + 6 * i);
    chk($sformatf("f%0d_d%0d_an", k, i), 16'(an), 16'(ea));
    chk($sformatf("f%0d_d%0d_seg", k, i), 16'(seg), 16'(es));
    chk($sformatf("f%0d_d%0d_dp", k, i), 16'(dp), 16'(ed));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    load     = 1'b1;
    data_in  = 16'hABCD;
    dp_in    = 4'hF;
    blank_lz = 1'b0;

    // Reset held with load pulsing: nothing may be captured or shown.
    repeat (3) step();
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_seg", 16'(seg), 16'h007F);
    chk("rst_dp", 16'(dp), 16'h0001);
    chk("rst_fd", 16'(frame_done), 16'h0000);

    load    = 1'b0;
    data_in = 16'h0000;
    dp_in   = 4'h0;
    rst_n   = 1'b1;
    cyc     = 0;

    // First digit timing after release.
    wait_cyc(2);  chk("rel_c2_an", 16'(an), 16'h000F);
    wait_cyc(3);  chk("rel_c3_an", 16'(an), 16'h000E);
    chk("rel_c3_seg", 16'(seg), 16'h0040);
    chk("rel_c3_dp", 16'(dp), 16'h0001);
    wait_cyc(6);  chk("rel_c6_an", 16'(an), 16'h000E);
    wait_cyc(7);  chk("rel_c7_an", 16'(an), 16'h000F);
    wait_cyc(8);  chk("rel_c8_an", 16'(an), 16'h000F);
    wait_cyc(9);  chk("rel_c9_an", 16'(an), 16'h000D);

    // Load 12F0 during frame 0; it must appear only from frame 1.
    wait_cyc(10);
    load = 1'b1; data_in = 16'h12F0;
    step();
    load = 1'b0; data_in = 16'h0000;
    chk_digit(0, 2, 7'h40, 1'b1);

    wait_cyc(22); chk("fd_c22", 16'(frame_done), 16'h0000);
    wait_cyc(23); chk("fd_c23", 16'(frame_done), 16'h0001);
    wait_cyc(24); chk("fd_c24", 16'(frame_done), 16'h0000);

    chk_digit(1, 0, 7'b1000000, 1'b1);
    // Stage 0050 mid-frame; frame 1 must still show 12F0.
    wait_cyc(30);
    load = 1'b1; data_in = 16'h0050;
    step();
    load = 1'b0; data_in = 16'h0000;
    chk_digit(1, 1, 7'b0001110, 1'b1);
    chk_digit(1, 2, 7'b0100100, 1'b1);
    chk_digit(1, 3, 7'b1111001, 1'b1);
    wait_cyc(47); chk("fd_c47", 16'(frame_done), 16'h0001);
    wait_cyc(48); chk("fd_c48", 16'(frame_done), 16'h0000);

    // Leading-zero blanking on 0050.
    blank_lz = 1'b1;
    chk_digit(2, 0, 7'b1000000, 1'b1);
    chk_digit(2, 1, 7'b0010010, 1'b1);
    chk_digit(2, 2, 7'h7F, 1'b1);
    chk_digit(2, 3, 7'h7F, 1'b1);
    wait_cyc(72);
    blank_lz = 1'b0;
    chk_digit(3, 1, 7'b0010010, 1'b1);
    chk_digit(3, 2, 7'b1000000, 1'b1);
    chk_digit(3, 3, 7'b1000000, 1'b1);

    // Tear-free: two loads during frame 4, last one wins in frame 5.
    chk_digit(4, 0, 7'b1000000, 1'b1);
    wait_cyc(102);
    load = 1'b1; data_in = 16'h1111;
    step();
    load = 1'b0;
    chk_digit(4, 1, 7'b0010010, 1'b1);
    wait_cyc(108);
    load = 1'b1; data_in = 16'h2222;
    step();
    load = 1'b0; data_in = 16'h0000;
    chk_digit(4, 2, 7'b1000000, 1'b1);
    chk_digit(4, 3, 7'b1000000, 1'b1);
    chk_digit(5, 0, 7'b0100100, 1'b1);
    chk_digit(5, 1, 7'b0100100, 1'b1);
    chk_digit(5, 2, 7'b0100100, 1'b1);
    chk_digit(5, 3, 7'b0100100, 1'b1);

    // Load coinciding with the boundary cycle goes straight to the display.
    wait_cyc(143);
    chk("fd_c143", 16'(frame_done), 16'h0001);
    load = 1'b1; data_in = 16'hFFFF; dp_in = 4'b0001;
    step();
    load = 1'b0; data_in = 16'h0000; dp_in = 4'b0000;
    chk_digit(6, 0, 7'b0001110, 1'b0);
    chk_digit(6, 1, 7'b0001110, 1'b1);
    chk_digit(6, 2, 7'b0001110, 1'b1);

    // Asynchronous reset in the middle of digit 2's DRIVE.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 16'(an), 16'h000F);
    chk("mid_rst_seg", 16'(seg), 16'h007F);
    chk("mid_rst_dp", 16'(dp), 16'h0001);
    chk("mid_rst_fd", 16'(frame_done), 16'h0000);
    cyc = 0;
    repeat (2) step();
    rst_n = 1'b1;
    cyc   = 0;
    wait_cyc(3);
    chk("rst2_c3_an", 16'(an), 16'h000E);
    chk("rst2_c3_seg", 16'(seg), 16'h0040);
    chk_digit(1, 0, 7'b1000000, 1'b1);
    chk_digit(1, 3, 7'b1000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, sets the DRIVE dwell per digit in clk cycles; legal values are 2 and above.
REQ-002 Parameter BLANK_CYC, default 1000, sets the all-anodes-off dwell between digits in clk cycles; legal values are 1 and above.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port data_in, input, 16 bits: four hex nibbles; nibble i = data_in[4i+3:4i] drives digit i, digit 3 being most significant.
REQ-006 Port dp_in, input, 4 bits: decimal point request per digit, active-high.
REQ-007 Port load, input, 1 bit: capture strobe for data_in and dp_in.
REQ-008 Port blank_lz, input, 1 bit: enables leading-zero blanking; sampled live.
REQ-009 Port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-010 Port dp, output, 1 bit: decimal point, active-low.
REQ-011 Port an, output, 4 bits: digit anodes, active-low; an[i] selects digit i.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 The FSM SHALL have two states, BLANK and DRIVE, plus a 2-bit digit index idx and a dwell counter.
- BLANK: all anodes off for BLANK_CYC cycles, then go to DRIVE.
- DRIVE: an[idx]=0 for TICK_DIV cycles, then go to BLANK with idx+1 (3 wraps to 0).
REQ-014 The per-digit period SHALL be BLANK_CYC+TICK_DIV cycles and the frame period SHALL be 4x that.
REQ-015 A load=1 in any cycle SHALL capture data_in/dp_in into a pending register; with several loads, the last one wins.
REQ-016 The pending register SHALL be copied to the active register only at the frame boundary (DRIVE of idx 3 ending), so no frame ever mixes old and new data.
REQ-017 When load coincides with the frame boundary, the active register SHALL take data_in/dp_in directly that cycle.
REQ-018 frame_done SHALL pulse high for exactly the one cycle in which the boundary transfer occurs, whether or not a load is pending.
REQ-019 Leading-zero blanking: with blank_lz=1, digit i (i=3..1) SHALL show seg=7'h7F and dp=1, with its anode still driven, when every active nibble from 3 down to i is 0. Digit 0 is never blanked.
REQ-020 Nibble decode SHALL be the standard hex font; for example 0=1000000, 1=1111001, 2=0100100, 5=0010010, F=0001110.
REQ-021 seg, dp and an SHALL be registered and SHALL reflect FSM state with exactly one cycle of latency.
REQ-022 While in BLANK, an SHALL be 4'b1111, seg SHALL be 7'h7F and dp SHALL be 1.
REQ-023 Parameter changes are not supported at run time.

Reset
REQ-024 Asserting rst_n low SHALL immediately force the following, regardless of state:
- an=4'b1111, seg=7'h7F, dp=1, frame_done=0;
- FSM=BLANK, idx=0, counter=0;
- pending and active registers = 0.
REQ-025 After release, the first DRIVE SHALL be idx 0, with an=4'b1110 first visible BLANK_CYC+1 cycles after the first clk edge.
REQ-026 Reset asserted mid-DRIVE SHALL discard pending data; no partial frame resumes.

Structure
REQ-027 A shared package SHALL hold the state enum (BLANK, DRIVE) and the 16-entry active-low segment font constant.
REQ-028 The decode SHALL be one combinational sub-module, hex2seg (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.

Verification (TICK_DIV=4, BLANK_CYC=2)
REQ-029 Reset: hold rst_n=0 with load pulsed -> an=1111, seg=7F, dp=1; after release -> an=1110 after 3 cycles, lasting 4 cycles, then 2 cycles of 1111.
REQ-030 Scan: load 16'h12F0 then wait one boundary -> per frame the outputs SHALL be:
- an=1110 with seg=1000000;
- an=1101 with seg=0001110;
- an=1011 with seg=0100100;
- an=0111 with seg=1111001;
- one frame_done pulse per 24 cycles.
REQ-031 Blanking: data 16'h0050, blank_lz=1 -> digits 3 and 2 SHALL show seg=7F, digit 1 seg=0010010, digit 0 seg=1000000; with blank_lz=0, digits 3 and 2 SHALL show 1000000.
REQ-032 Tear-free: load 16'h1111 then 16'h2222 mid-frame -> the current frame is unchanged and the next frame shows only 2 on every digit.
REQ-033 Coincident load: load 16'hFFFF with dp_in=4'b0001 in the boundary cycle -> the next digit 0 shows seg=0001110 with dp=0.
REQ-034 Mid-DRIVE reset: drop rst_n during an=1011 -> same-cycle an=1111, and the sequence restarts at idx 0 showing 0.
